vga_fb_rect_writer: RTL and testbench
=====================================

// Module: vga_fb_rect_writer
// PURPOSE
// - Processor-side drawing engine and write master for frame buffer port A; the VGA signal generator reads port B.
// - Accepts one rectangle command over a valid/ready handshake.
// - Walks the clipped rectangle in raster order, producing FB_ADDR/FB_DATA/FB_WE, one pixel per cycle.
// - Offloads per-pixel stores from the processor (screen clear, sprite blocks).
// PARAMETERS
// - H_PIXELS  160  visible columns; x range 0..H_PIXELS-1
// - V_PIXELS  120  visible rows; y range 0..V_PIXELS-1
// - X_W       8    x coordinate width
// - Y_W       7    y coordinate width
// - ADDR_W    15   frame buffer address width; must equal X_W+Y_W
// PORTS
// - CLK          in   1       system clock; also frame buffer port A clock
// - RESET        in   1       synchronous, active-high reset
// - CMD_VALID    in   1       command present
// - CMD_READY    out  1       engine idle; command accepted when CMD_VALID && CMD_READY
// - CMD_OP       in   1       0 = FILL with CMD_COLOUR; 1 = INVERT (macro-dependent)
// - CMD_COLOUR   in   1       pixel value for FILL
// - CMD_X0/X1    in   X_W     inclusive left/right column
// - CMD_Y0/Y1    in   Y_W     inclusive top/bottom row
// - FB_ADDR      out  ADDR_W  port A address = {y, x}
// - FB_DATA      out  1       port A write data
// - FB_WE        out  1       port A write enable
// - FB_DATA_OUT  in   1       port A read data; valid one cycle after FB_ADDR is presented
// - BUSY         out  1       high from acceptance until the DONE cycle
// - DONE         out  1       single-cycle pulse when a command completes
// BEHAVIOUR
// - Reset values: CMD_READY=1, FB_ADDR=0, FB_DATA=0, FB_WE=0, BUSY=0, DONE=0, state=IDLE.
// - Command latch and clipping:
//   - All command fields are latched on acceptance; input changes afterwards are ignored.
//   - Clipping: X1 is clamped to H_PIXELS-1 and Y1 to V_PIXELS-1.
//   - Empty command: X0 > clamped X1, Y0 > clamped Y1, X0 >= H_PIXELS, or Y0 >= V_PIXELS.
//   - An empty command performs no writes and pulses DONE one cycle after acceptance.
// - States:
//   - IDLE --accept--> FILL (OP=0), RD (OP=1), or DONE (empty command).
//   - FILL: FB_WE=1, FB_DATA=colour, one pixel per cycle.
//   - RD: FB_WE=0, address presented. RD -> WR.
//   - WR: FB_WE=1, FB_DATA=~FB_DATA_OUT, same address. WR -> RD, or -> DONE after the last pixel.
//   - DONE: DONE=1, BUSY=0 -> IDLE.
// - Timing:
//   - Acceptance at edge N. The first FILL write is presented in cycle N+1.
//   - A FILL of W*H pixels takes W*H cycles of FB_WE, then one DONE cycle.
//   - CMD_READY returns to 1 in the cycle after DONE.
//   - INVERT takes 2 cycles per pixel.
// - Raster order: x increments from X0 to X1. At X1, x wraps to X0 and y increments. The final pixel is (X1,Y1).
// - Outputs are registered. FB_ADDR is held stable while FB_WE=1. FB_WE never asserts in IDLE or DONE.
// - CMD_READY=0 in every state except IDLE. CMD_VALID outside IDLE is ignored and nothing is queued.
// - Reset mid-command aborts the command: FB_WE=0 after the reset edge, no DONE pulse, return to IDLE.
// - A 1x1 rectangle (X0=X1, Y0=Y1) writes exactly one pixel.
// CONFIGURATION
// - FB_DRAW_INVERT_EN defined: CMD_OP=1 executes the INVERT read-modify-write path (RD/WR states).
// - FB_DRAW_INVERT_EN undefined:
//   - RD/WR logic and FB_DATA_OUT usage are removed.
//   - CMD_OP is ignored and every command executes as FILL.
// TESTING
// - Reset, then FILL X0=0,X1=159,Y0=0,Y1=119,colour=1
//   -> 19200 writes, first addr 0x0000, last addr {7'd119,8'd159}; DONE 1 cycle later.
// - FILL (10,5)-(12,6), colour=0
//   -> 6 writes in order {5,10},{5,11},{5,12},{6,10},{6,11},{6,12}, back-to-back FB_WE.
// - FILL X1=200, Y1=127
//   -> clipped to x<=159, y<=119; no address with x>159 or y>119 is written.
// - Empty command X0=20, X1=10
//   -> zero FB_WE cycles; DONE one cycle after acceptance; CMD_READY high the next cycle.
// - INVERT (3,3)-(4,3) with model pixels 1,0 (macro on)
//   -> RD/WR alternating, writes 0 then 1; 4 busy cycles plus DONE.
// - RESET asserted on the 50th write of a large FILL
//   -> FB_WE=0 the next cycle, no DONE pulse, CMD_READY=1; a new command is accepted normally.

Source files
------------

// File: rtl/vga_fb_rect_writer.sv
// Rectangle drawing engine: walks a clipped rectangle in raster order and writes frame buffer port A.
// Optional INVERT read-modify-write path enabled by defining FB_DRAW_INVERT_EN.
module vga_fb_rect_writer #(
  parameter int unsigned H_PIXELS = 160,
  parameter int unsigned V_PIXELS = 120,
  parameter int unsigned X_W      = 8,
  parameter int unsigned Y_W      = 7,
  parameter int unsigned ADDR_W   = 15
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_OP,
  input  logic              CMD_COLOUR,
  input  logic [X_W-1:0]    CMD_X0,
  input  logic [X_W-1:0]    CMD_X1,
  input  logic [Y_W-1:0]    CMD_Y0,
  input  logic [Y_W-1:0]    CMD_Y1,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic              FB_DATA,
  output logic              FB_WE,
  input  logic              FB_DATA_OUT,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_PIXELS - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_PIXELS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RD,
    S_WR,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [X_W-1:0] x0_q, x0_d;
  logic [X_W-1:0] x1_q, x1_d;
  logic [Y_W-1:0] y1_q, y1_d;
  logic           data_q, data_d;
  logic           we_q, we_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;
  logic           ready_q, ready_d;

  logic [X_W-1:0] x1_clip;
  logic [Y_W-1:0] y1_clip;
  logic           cmd_empty;
  logic           cmd_invert;
  logic           last_px;
  logic [X_W-1:0] x_adv;
  logic [Y_W-1:0] y_adv;

  // Clip the incoming command and decide whether it touches any pixel
  always_comb begin
    x1_clip   = (CMD_X1 > X_LAST) ? X_LAST : CMD_X1;
    y1_clip   = (CMD_Y1 > Y_LAST) ? Y_LAST : CMD_Y1;
    cmd_empty = (CMD_X0 > X_LAST) || (CMD_Y0 > Y_LAST) ||
                (CMD_X0 > x1_clip) || (CMD_Y0 > y1_clip);
  end

`ifdef FB_DRAW_INVERT_EN
  assign cmd_invert = CMD_OP;
  // Read data only arrives during WR, so the inverted value bypasses the data register
  assign FB_DATA    = (state_q == S_WR) ? ~FB_DATA_OUT : data_q;
`else
  logic unused_inv_inputs;
  assign unused_inv_inputs = CMD_OP ^ FB_DATA_OUT;
  assign cmd_invert        = 1'b0;
  assign FB_DATA           = data_q;
`endif

  // Raster step: x wraps to the left edge at the right edge, then y advances
  always_comb begin
    last_px = (x_q == x1_q) && (y_q == y1_q);
    x_adv   = (x_q == x1_q) ? x0_q : x_q + X_W'(1);
    y_adv   = (x_q == x1_q) ? y_q + Y_W'(1) : y_q;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    x0_d    = x0_q;
    x1_d    = x1_q;
    y1_d    = y1_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    busy_d  = busy_q;
    ready_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (CMD_VALID && ready_q) begin
          ready_d = 1'b0;
          x0_d    = CMD_X0;
          x1_d    = x1_clip;
          y1_d    = y1_clip;
          if (cmd_empty) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            x_d    = CMD_X0;
            y_d    = CMD_Y0;
            busy_d = 1'b1;
            if (cmd_invert) begin
              state_d = S_RD;
            end else begin
              state_d = S_FILL;
              we_d    = 1'b1;
              data_d  = CMD_COLOUR;
            end
          end
        end
      end
      S_FILL: begin
        if (last_px) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          x_d  = x_adv;
          y_d  = y_adv;
          we_d = 1'b1;
        end
      end
`ifdef FB_DRAW_INVERT_EN
      S_RD: begin
        state_d = S_WR;
        we_d    = 1'b1;
      end
      S_WR: begin
        if (last_px) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_RD;
          x_d     = x_adv;
          y_d     = y_adv;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      data_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      x0_q    <= x0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      data_q  <= data_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign FB_ADDR   = {y_q, x_q};
  assign FB_WE     = we_q;
  assign DONE      = done_q;
  assign BUSY      = busy_q;
  assign CMD_READY = ready_q;

endmodule

// File: tb/tb_vga_fb_rect_writer.sv
// Scoreboard bench for vga_fb_rect_writer with a frame buffer port A model and a pixel-level reference.
module tb_vga_fb_rect_writer;

`ifdef FB_DRAW_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  typedef struct packed {
    logic [14:0] addr;
    logic        data;
  } wr_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_OP;
  logic        CMD_COLOUR;
  logic [7:0]  CMD_X0, CMD_X1;
  logic [6:0]  CMD_Y0, CMD_Y1;
  logic [14:0] FB_ADDR;
  logic        FB_DATA;
  logic        FB_WE;
  logic        FB_DATA_OUT;
  logic        BUSY;
  logic        DONE;

  vga_fb_rect_writer dut (
    .CLK(CLK), .RESET(RESET),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP), .CMD_COLOUR(CMD_COLOUR),
    .CMD_X0(CMD_X0), .CMD_X1(CMD_X1), .CMD_Y0(CMD_Y0), .CMD_Y1(CMD_Y1),
    .FB_ADDR(FB_ADDR), .FB_DATA(FB_DATA), .FB_WE(FB_WE), .FB_DATA_OUT(FB_DATA_OUT),
    .BUSY(BUSY), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Frame buffer port A: synchronous read, read-before-write
  logic ram [0:32767];
  logic rd_q = 1'b0;
  always @(posedge CLK) begin
    rd_q <= ram[FB_ADDR];
    if (FB_WE) ram[FB_ADDR] <= FB_DATA;
  end
  assign FB_DATA_OUT = rd_q;

  logic mdl [0:32767];
  wr_t  wq[$];
  int   dq[$];
  int   cyc = 0;
  int   err = 0;
  int   chk = 0;
  int   done_seen = 0;
  bit   mon_en = 1'b0;

  always @(posedge CLK) cyc = cyc + 1;

  // Monitor: every write and every DONE pulse is matched against the scoreboard
  always @(negedge CLK) begin
    if (mon_en) begin
      if (FB_WE) begin
        chk++;
        if (wq.size() == 0) begin
          err++;
          $display("FAIL unexpected_write addr=%h data=%b", FB_ADDR, FB_DATA);
        end else begin
          wr_t e;
          e = wq.pop_front();
          if (FB_ADDR !== e.addr || FB_DATA !== e.data || BUSY !== 1'b1 || CMD_READY !== 1'b0) begin
            err++;
            $display("FAIL write got addr=%h data=%b busy=%b rdy=%b want addr=%h data=%b busy=1 rdy=0",
                     FB_ADDR, FB_DATA, BUSY, CMD_READY, e.addr, e.data);
          end
        end
      end
      if (DONE) begin
        chk++;
        done_seen++;
        if (dq.size() == 0) begin
          err++;
          $display("FAIL unexpected_done cycle=%0d", cyc);
        end else begin
          int exp_c;
          exp_c = dq.pop_front();
          if (cyc != exp_c || wq.size() != 0 || BUSY !== 1'b0 || FB_WE !== 1'b0) begin
            err++;
            $display("FAIL done got cycle=%0d pending=%0d busy=%b we=%b want cycle=%0d pending=0 busy=0 we=0",
                     cyc, wq.size(), BUSY, FB_WE, exp_c);
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    chk++;
    if (got !== want) begin
      err++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic poke(input int a, input logic v);
    ram[a] <= v;
    mdl[a] = v;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    wq.delete();
    dq.delete();
  endtask

  // Issue one command, push its expected writes and DONE cycle, then wait for completion
  task automatic issue(input logic op, input logic colour, input int x0, input int x1,
                       input int y0, input int y1);
    int  n, acc, xe, ye, d0, lim, k;
    bit  inv, empty;
    k = 0;
    while (CMD_READY !== 1'b1 && k < 200) begin
      @(posedge CLK); #1; k++;
    end
    d0 = done_seen;
    CMD_OP = op; CMD_COLOUR = colour;
    CMD_X0 = 8'(x0); CMD_X1 = 8'(x1); CMD_Y0 = 7'(y0); CMD_Y1 = 7'(y1);
    CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    acc = cyc;
    inv = op && INV_EN;
    xe = (x1 > 159) ? 159 : x1;
    ye = (y1 > 119) ? 119 : y1;
    empty = (x0 > xe) || (y0 > ye);
    n = 0;
    if (!empty) begin
      for (int y = y0; y <= ye; y++) begin
        for (int x = x0; x <= xe; x++) begin
          logic [14:0] a;
          logic        d;
          a = {7'(y), 8'(x)};
          d = inv ? ~mdl[a] : colour;
          mdl[a] = d;
          wq.push_back('{addr: a, data: d});
          n++;
        end
      end
    end
    dq.push_back(acc + (inv ? 2 * n : n));
    check("ready_low_after_accept", 32'(CMD_READY), 32'd0);
    if (empty) check("empty_done_next_cycle", 32'(DONE), 32'd1);
    // Garbage held on the command port while the engine is busy must be ignored
    CMD_OP = 1'($urandom); CMD_COLOUR = 1'($urandom);
    CMD_X0 = 8'($urandom); CMD_X1 = 8'($urandom); CMD_Y0 = 7'($urandom); CMD_Y1 = 7'($urandom);
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    if (empty) check("empty_ready_after_done", 32'(CMD_READY), 32'd1);
    lim = 2 * n + 20;
    k = 0;
    while (done_seen < d0 + 1 && k < lim) begin
      @(posedge CLK); #1; k++;
    end
    if (done_seen < d0 + 1) begin
      chk++; err++;
      $display("FAIL done_timeout got=none want=done within %0d cycles", lim);
      do_reset();
    end
  endtask

  initial begin
    int d0;
    RESET = 1'b1; CMD_VALID = 1'b0; CMD_OP = 1'b0; CMD_COLOUR = 1'b0;
    CMD_X0 = '0; CMD_X1 = '0; CMD_Y0 = '0; CMD_Y1 = '0;
    for (int i = 0; i < 32768; i++) poke(i, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    check("rst_ready", 32'(CMD_READY), 32'd1);
    check("rst_addr", 32'(FB_ADDR), 32'd0);
    check("rst_data", 32'(FB_DATA), 32'd0);
    check("rst_we", 32'(FB_WE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_done", 32'(DONE), 32'd0);
    mon_en = 1'b1;

    issue(1'b0, 1'b1, 0, 159, 0, 119);
    issue(1'b0, 1'b0, 10, 12, 5, 6);
    issue(1'b0, 1'b1, 150, 200, 115, 127);
    issue(1'b0, 1'b1, 20, 10, 0, 5);
    issue(1'b0, 1'b1, 170, 200, 3, 4);
    issue(1'b0, 1'b1, 7, 7, 9, 9);

    poke({7'd3, 8'd3}, 1'b1);
    poke({7'd3, 8'd4}, 1'b0);
    @(posedge CLK); #1;
    issue(1'b1, 1'b0, 3, 4, 3, 3);

    for (int t = 0; t < 40; t++) begin
      int x0, y0;
      x0 = int'($urandom_range(0, 175));
      y0 = int'($urandom_range(0, 125));
      issue(1'($urandom), 1'($urandom), x0, x0 + int'($urandom_range(0, 12)) - 2,
            y0, y0 + int'($urandom_range(0, 6)) - 1);
    end

    // Abort a large FILL with reset during its 50th write
    CMD_OP = 1'b0; CMD_COLOUR = 1'b1;
    CMD_X0 = 8'd0; CMD_X1 = 8'd159; CMD_Y0 = 7'd0; CMD_Y1 = 7'd119;
    CMD_VALID = 1'b1;
    @(posedge CLK); #1;
    CMD_VALID = 1'b0;
    for (int x = 0; x < 160; x++) begin
      wq.push_back('{addr: {7'd0, 8'(x)}, data: 1'b1});
    end
    d0 = done_seen;
    repeat (49) @(posedge CLK);
    #1;
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    wq.delete();
    dq.delete();
    check("abort_we", 32'(FB_WE), 32'd0);
    check("abort_ready", 32'(CMD_READY), 32'd1);
    check("abort_busy", 32'(BUSY), 32'd0);
    repeat (4) @(posedge CLK);
    #1;
    check("abort_no_done", 32'(done_seen), 32'(d0));
    for (int i = 0; i < 32768; i++) mdl[i] = ram[i];
    issue(1'b0, 1'b0, 0, 3, 0, 1);
    issue(1'b1, 1'b1, 0, 2, 0, 0);

    repeat (3) @(posedge CLK);
    #1;
    check("sb_writes_drained", 32'(wq.size()), 32'd0);
    check("sb_done_drained", 32'(dq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
